// File: rtl/irq_pkg.sv
// irq_pkg: shared constants and the request-select encoding for irq_timer_ctrl.
// Holds the default prescaler shift, the cfg_data field positions and the
// arbiter select codes (s_interrupcion) used by the top level.
package irq_pkg;
    localparam int DEF_BASE_SHIFT = 4;
    localparam int BASE_MSB       = 7;
    localparam int BASE_LSB       = 6;
    localparam int UMBRAL_MSB     = 5;
    localparam int UMBRAL_LSB     = 0;
    typedef enum logic [1:0] {
        IRQ_SEL_NONE = 2'b00,
        IRQ_SEL_EXT  = 2'b01,
        IRQ_SEL_TMR  = 2'b10
    } irq_sel_e;
endpackage

// File: rtl/irq_prescaler_timer.sv
// irq_prescaler_timer: programmable periodic timer (prescaler + tick counter) with sticky overrun.
// Ports: clk, reset_n (async, active-low); cfg_we_i/cfg_data_i config write
// ({base, umbral}); pend_i = timer request still pending; expire_o one-cycle
// strobe on the wrap tick; overrun_o sticky expiry-while-pending flag.
module irq_prescaler_timer import irq_pkg::*; #(
    parameter int BASE_SHIFT = DEF_BASE_SHIFT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cfg_we_i,
    input  logic [7:0] cfg_data_i,
    input  logic       pend_i,
    output logic       expire_o,
    output logic       overrun_o
);
    localparam int PW = (3 * BASE_SHIFT > 0) ? 3 * BASE_SHIFT : 1;
    logic [1:0]    base_q, base_d;
    logic [5:0]    umbral_q, umbral_d, tick_q, tick_d;
    logic [PW-1:0] presc_q, presc_d, presc_max;
    logic          ovr_q, ovr_d, active, tick, wrap;
    always_comb begin
        // divide-1 as a mask: all ones below bit BASE_SHIFT*base
        presc_max = ~({PW{1'b1}} << (BASE_SHIFT * int'(base_q)));
        active    = umbral_q != 6'd0;
        tick      = active && presc_q == presc_max;
        wrap      = tick && tick_q == umbral_q - 6'd1;
        // a config write on the same edge wins over the wrap
        expire_o  = wrap && !cfg_we_i;
        base_d    = cfg_we_i ? cfg_data_i[BASE_MSB:BASE_LSB] : base_q;
        umbral_d  = cfg_we_i ? cfg_data_i[UMBRAL_MSB:UMBRAL_LSB] : umbral_q;
        presc_d   = (cfg_we_i || tick || !active) ? '0 : presc_q + 1'b1;
        tick_d    = (cfg_we_i || wrap) ? '0 : tick ? tick_q + 6'd1 : tick_q;
        ovr_d     = !cfg_we_i && (ovr_q || (wrap && pend_i));
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q   <= '0;
            umbral_q <= '0;
            presc_q  <= '0;
            tick_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            base_q   <= base_d;
            umbral_q <= umbral_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            ovr_q    <= ovr_d;
        end
    end
    assign overrun_o = ovr_q;
endmodule

// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl: external-interrupt and periodic-timer request source with non-nesting ISR tracking.
// Ports: clk, reset_n (async, active-low); irq_in external level line;
// enable/cfg_data timer config write; push/pop control-unit stack strobes;
// interrupcion/clock_out one-cycle request pulses; in_service ISR active;
// tmr_overrun sticky timer overrun.
// Build option: define IRQ_SYNC_EN to add a 2-flop synchroniser on irq_in.
module irq_timer_ctrl import irq_pkg::*; #(
    parameter int BASE_SHIFT = DEF_BASE_SHIFT,
    parameter int NEST_W     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       irq_in,
    input  logic       enable,
    input  logic [7:0] cfg_data,
    input  logic       push,
    input  logic       pop,
    output logic       interrupcion,
    output logic       clock_out,
    output logic       in_service,
    output logic       tmr_overrun
);
    logic              irq_s, prev_q, rise, expire, idle, track;
    logic              irq_pend_q, irq_pend_d, tmr_pend_q, tmr_pend_d;
    logic              int_q, clk_q, isv_q, isv_d;
    logic [NEST_W-1:0] nest_q, nest_d;
    irq_sel_e          sel;
`ifdef IRQ_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[0], irq_in};
    end
    assign irq_s = sync_q[1];
`else
    assign irq_s = irq_in;
`endif
    irq_prescaler_timer #(.BASE_SHIFT(BASE_SHIFT)) u_tmr (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_we_i  (enable),
        .cfg_data_i(cfg_data),
        .pend_i    (tmr_pend_q),
        .expire_o  (expire),
        .overrun_o (tmr_overrun)
    );
    always_comb begin
        rise       = irq_s && !prev_q;
        idle       = !isv_q && !int_q && !clk_q;
        // stack strobes during the pulse cycle belong to ISR entry
        track      = isv_q && !int_q && !clk_q;
        sel        = !idle ? IRQ_SEL_NONE : irq_pend_q ? IRQ_SEL_EXT :
                     tmr_pend_q ? IRQ_SEL_TMR : IRQ_SEL_NONE;
        // an edge while already pending is coalesced
        irq_pend_d = irq_pend_q ? sel != IRQ_SEL_EXT : rise;
        tmr_pend_d = !enable && (expire || (tmr_pend_q && sel != IRQ_SEL_TMR));
        nest_d     = (!track || push == pop) ? nest_q :
                     push ? (&nest_q ? nest_q : nest_q + 1'b1) :
                     (|nest_q ? nest_q - 1'b1 : nest_q);
        isv_d      = sel != IRQ_SEL_NONE || (isv_q && !(track && pop && !push && ~|nest_q));
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= 1'b0;
            irq_pend_q <= 1'b0;
            tmr_pend_q <= 1'b0;
            int_q      <= 1'b0;
            clk_q      <= 1'b0;
            isv_q      <= 1'b0;
            nest_q     <= '0;
        end else begin
            prev_q     <= irq_s;
            irq_pend_q <= irq_pend_d;
            tmr_pend_q <= tmr_pend_d;
            int_q      <= sel == IRQ_SEL_EXT;
            clk_q      <= sel == IRQ_SEL_TMR;
            isv_q      <= isv_d;
            nest_q     <= nest_d;
        end
    end
    assign interrupcion = int_q;
    assign clock_out    = clk_q;
    assign in_service   = isv_q;
endmodule
